// File: rtl/board_renderer.sv
// Two-stage pixel pipeline that draws a 9x10 board with pieces, grid and a blinking cursor.
// Stage 1 tracks the cell position and issues the board read; stage 2 picks the colour.
module board_renderer (
    input  logic        pclk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        valid_in,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic [3:0]  cursor_col,
    input  logic [3:0]  cursor_row,
    input  logic        cursor_en,
    output logic [6:0]  brd_addr,
    input  logic [4:0]  brd_data,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb
);

    localparam logic [9:0]  BOARD_X0  = 10'd104;
    localparam logic [9:0]  BOARD_X1  = 10'd535;
    localparam logic [5:0]  CELL_LAST = 6'd47;
    localparam logic [11:0] COL_BLACK = 12'h000;
    localparam logic [11:0] COL_CURS  = 12'h0F0;
    localparam logic [11:0] COL_RED   = 12'hF00;
    localparam logic [11:0] COL_DARK  = 12'h222;
    localparam logic [11:0] COL_WOOD  = 12'hDA6;

    logic        valid_r, hs1_r, vs1_r, row_ok_r, inb_r;
    logic [5:0]  cx_r, ry_r;
    logic [3:0]  col_r, row_r;
    logic [4:0]  frame_r;

    logic        in_board_s, line_start_s, row_ok_nxt_s;
    logic [5:0]  cx_nxt_s, ry_nxt_s;
    logic [3:0]  col_nxt_s, row_nxt_s;
    logic [6:0]  addr_nxt_s;
    logic        near_edge_s, cursor_hit_s, piece_hit_s, grid_hit_s;
    logic [11:0] rgb_nxt_s;
    logic        unused_type_s;

    // The piece type bits are carried by the memory but never change the colour.
    assign unused_type_s = ^brd_data[2:0];

    // Stage-1 next state: column/row counters, row validity and board address.
    always_comb begin
        in_board_s   = valid_in && (h_cnt >= BOARD_X0) && (h_cnt <= BOARD_X1);
        line_start_s = valid_in && !valid_r;
        cx_nxt_s     = cx_r;
        col_nxt_s    = col_r;
        ry_nxt_s     = ry_r;
        row_nxt_s    = row_r;
        row_ok_nxt_s = row_ok_r;
        addr_nxt_s   = brd_addr;

        if (in_board_s) begin
            if (h_cnt == BOARD_X0) begin
                cx_nxt_s  = 6'd0;
                col_nxt_s = 4'd0;
            end else if (cx_r == CELL_LAST) begin
                cx_nxt_s  = 6'd0;
                col_nxt_s = col_r + 4'd1;
            end else begin
                cx_nxt_s  = cx_r + 6'd1;
            end
        end else begin
            cx_nxt_s  = cx_r;
            col_nxt_s = col_r;
        end

        // Rows only become trustworthy once a top line (v_cnt=0) has been seen.
        if (line_start_s && (v_cnt == 10'd0)) begin
            ry_nxt_s     = 6'd0;
            row_nxt_s    = 4'd0;
            row_ok_nxt_s = 1'b1;
        end else if (line_start_s) begin
            if (ry_r == CELL_LAST) begin
                ry_nxt_s  = 6'd0;
                row_nxt_s = row_r + 4'd1;
            end else begin
                ry_nxt_s  = ry_r + 6'd1;
            end
        end else begin
            ry_nxt_s  = ry_r;
            row_nxt_s = row_r;
        end

        if (in_board_s) begin
            addr_nxt_s = {row_nxt_s, 3'b000} + {3'b000, row_nxt_s} + {3'b000, col_nxt_s};
        end else begin
            addr_nxt_s = brd_addr;
        end
    end

    // Stage-1 registers and the frame counter.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            valid_r  <= 1'b0;
            hs1_r    <= 1'b1;
            vs1_r    <= 1'b1;
            cx_r     <= 6'd0;
            col_r    <= 4'd0;
            ry_r     <= 6'd0;
            row_r    <= 4'd0;
            row_ok_r <= 1'b0;
            inb_r    <= 1'b0;
            brd_addr <= 7'd0;
            frame_r  <= 5'd0;
        end else begin
            valid_r  <= valid_in;
            hs1_r    <= hsync_in;
            vs1_r    <= vsync_in;
            cx_r     <= cx_nxt_s;
            col_r    <= col_nxt_s;
            ry_r     <= ry_nxt_s;
            row_r    <= row_nxt_s;
            row_ok_r <= row_ok_nxt_s;
            inb_r    <= in_board_s && row_ok_nxt_s && (row_nxt_s <= 4'd9);
            brd_addr <= addr_nxt_s;
            if (vs1_r && !vsync_in) begin
                frame_r <= frame_r + 5'd1;
            end else begin
                frame_r <= frame_r;
            end
        end
    end

    // Stage-2 colour selection; brd_data belongs to the stage-1 pixel.
    always_comb begin
        near_edge_s  = (cx_r < 6'd2) || (cx_r > 6'd45) || (ry_r < 6'd2) || (ry_r > 6'd45);
        cursor_hit_s = cursor_en && frame_r[4] && (cursor_col <= 4'd8) && (cursor_row <= 4'd9)
                       && (col_r == cursor_col) && (row_r == cursor_row) && near_edge_s;
        piece_hit_s  = brd_data[4] && (cx_r >= 6'd4) && (cx_r <= 6'd44)
                       && (ry_r >= 6'd4) && (ry_r <= 6'd44);
        grid_hit_s   = (cx_r == 6'd24) || (ry_r == 6'd24);
        rgb_nxt_s    = COL_BLACK;

        if (!valid_r || !inb_r) begin
            rgb_nxt_s = COL_BLACK;
        end else if (cursor_hit_s) begin
            rgb_nxt_s = COL_CURS;
        end else if (piece_hit_s) begin
            rgb_nxt_s = brd_data[3] ? COL_RED : COL_DARK;
        end else if (grid_hit_s) begin
            rgb_nxt_s = COL_BLACK;
        end else begin
            rgb_nxt_s = COL_WOOD;
        end
    end

    // Stage-2 output registers keep syncs and colour on the same delay.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= COL_BLACK;
        end else begin
            hsync <= hs1_r;
            vsync <= vs1_r;
            rgb   <= rgb_nxt_s;
        end
    end

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: compact frames (short lines except selected full lines)
// with a 1-cycle board memory model and a 2-deep reference delay for the syncs.
module tb_board_renderer;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        hsync_in = 1'b1, vsync_in = 1'b1, valid_in = 1'b0;
    logic [9:0]  h_cnt = 10'd0, v_cnt = 10'd0;
    logic [3:0]  cursor_col = 4'd0, cursor_row = 4'd0;
    logic        cursor_en = 1'b0;
    logic [6:0]  brd_addr;
    logic [4:0]  brd_data = 5'd0;
    logic        hsync, vsync;
    logic [11:0] rgb;

    int total = 0;
    int bad = 0;
    int sync_mism = 0;
    int sync_cnt = 0;

    logic [4:0]  mem [0:89];
    logic [11:0] rgb_mem [0:479][0:639];
    logic [6:0]  addr_mem [0:479][0:639];
    bit          full_line [0:479];

    bit p_live [2];
    bit p_val [2];
    bit p_hs [2];
    bit p_vs [2];
    int p_h [2];
    int p_v [2];

    always #5 pclk = ~pclk;

    board_renderer dut (
        .pclk(pclk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .valid_in(valid_in), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
        .brd_addr(brd_addr), .brd_data(brd_data),
        .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    always @(negedge pclk) brd_data <= (brd_addr <= 7'd89) ? mem[brd_addr] : 5'd0;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic flush;
        for (int i = 0; i < 2; i++) begin
            p_live[i] = 1'b0;
            p_val[i]  = 1'b0;
        end
    endtask

    task automatic step(input bit val, input int h, input int v, input bit hs, input bit vs);
        @(negedge pclk);
        if (p_live[1]) begin
            sync_cnt++;
            if (hsync !== p_hs[1] || vsync !== p_vs[1]) sync_mism++;
        end
        if (p_live[1] && p_val[1]) rgb_mem[p_v[1]][p_h[1]] = rgb;
        if (p_live[0] && p_val[0]) addr_mem[p_v[0]][p_h[0]] = brd_addr;
        p_live[1] = p_live[0]; p_val[1] = p_val[0]; p_hs[1] = p_hs[0];
        p_vs[1] = p_vs[0]; p_h[1] = p_h[0]; p_v[1] = p_v[0];
        p_live[0] = 1'b1; p_val[0] = val; p_hs[0] = hs; p_vs[0] = vs; p_h[0] = h; p_v[0] = v;
        valid_in = val; h_cnt = 10'(h); v_cnt = 10'(v); hsync_in = hs; vsync_in = vs;
    endtask

    task automatic run_lines(input int v0, input int v1);
        for (int v = v0; v <= v1; v++) begin
            if (full_line[v]) begin
                for (int h = 0; h < 640; h++) step(1'b1, h, v, 1'b1, 1'b1);
            end else begin
                step(1'b1, 0, v, 1'b1, 1'b1);
            end
            step(1'b0, 0, 0, 1'b1, 1'b1);
            step(1'b0, 0, 0, 1'b0, 1'b1);
            step(1'b0, 0, 0, 1'b1, 1'b1);
        end
    endtask

    task automatic frame_blank;
        step(1'b0, 0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 0, 1'b1, 1'b1);
    endtask

    task automatic run_frame;
        run_lines(0, 479);
        frame_blank();
    endtask

    task automatic clear_setup;
        for (int v = 0; v < 480; v++) full_line[v] = 1'b0;
        for (int m = 0; m < 90; m++) mem[m] = 5'd0;
    endtask

    task automatic apply_reset;
        valid_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; h_cnt = 10'd0; v_cnt = 10'd0;
        reset = 1'b0;
        repeat (3) @(negedge pclk);
        reset = 1'b1;
        flush();
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        #1;
        total++; if (hsync !== 1'b1) begin bad++; $display("FAIL reset_hsync: got %b want 1", hsync); end
        total++; if (vsync !== 1'b1) begin bad++; $display("FAIL reset_vsync: got %b want 1", vsync); end
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb: got %h want 000", rgb); end
        total++; if (brd_addr !== 7'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", brd_addr); end
        repeat (3) @(negedge pclk);
        reset = 1'b1;
        flush();
    endtask

    task automatic test_empty_board;
        int ph[5] = '{128, 130, 50, 104, 536};
        int pv[5] = '{24, 30, 30, 30, 30};
        logic [11:0] ex[5] = '{12'h000, 12'hDA6, 12'h000, 12'hDA6, 12'h000};
        clear_setup();
        full_line[24] = 1'b1; full_line[30] = 1'b1;
        run_frame();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rgb_mem[pv[i]][ph[i]] !== ex[i]) begin
                bad++;
                $display("FAIL empty_px(%0d,%0d): got %h want %h", ph[i], pv[i], rgb_mem[pv[i]][ph[i]], ex[i]);
            end
        end
    endtask

    task automatic test_pieces;
        int ph[4] = '{128, 106, 108, 107};
        int pv[4] = '{10, 2, 10, 10};
        logic [11:0] ex[4] = '{12'hF00, 12'hDA6, 12'hF00, 12'hDA6};
        clear_setup();
        full_line[10] = 1'b1; full_line[2] = 1'b1;
        mem[0] = 5'b11000;
        run_frame();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rgb_mem[pv[i]][ph[i]] !== ex[i]) begin
                bad++;
                $display("FAIL red_px(%0d,%0d): got %h want %h", ph[i], pv[i], rgb_mem[pv[i]][ph[i]], ex[i]);
            end
        end
        mem[0] = 5'b10101;
        run_frame();
        total++;
        if (rgb_mem[10][128] !== 12'h222) begin
            bad++; $display("FAIL black_px(128,10): got %h want 222", rgb_mem[10][128]);
        end
    endtask

    task automatic test_brd_addr;
        clear_setup();
        full_line[0] = 1'b1; full_line[479] = 1'b1;
        run_frame();
        for (int c = 0; c < 9; c++) begin
            total++;
            if (addr_mem[0][104 + 48 * c] !== 7'(c)) begin
                bad++; $display("FAIL addr_first c=%0d: got %0d want %0d", c, addr_mem[0][104 + 48 * c], c);
            end
            total++;
            if (addr_mem[0][151 + 48 * c] !== 7'(c)) begin
                bad++; $display("FAIL addr_last c=%0d: got %0d want %0d", c, addr_mem[0][151 + 48 * c], c);
            end
        end
        total++; if (addr_mem[0][600] !== 7'd8) begin bad++; $display("FAIL addr_hold: got %0d want 8", addr_mem[0][600]); end
        total++; if (addr_mem[479][104] !== 7'd81) begin bad++; $display("FAIL addr_r9c0: got %0d want 81", addr_mem[479][104]); end
        total++; if (addr_mem[479][535] !== 7'd89) begin bad++; $display("FAIL addr_end: got %0d want 89", addr_mem[479][535]); end
    endtask

    task automatic test_cursor;
        int ph[4] = '{488, 490, 490, 535};
        int pv[4] = '{432, 432, 434, 456};
        logic [11:0] ex[4] = '{12'h0F0, 12'h0F0, 12'hDA6, 12'h0F0};
        clear_setup();
        full_line[432] = 1'b1; full_line[434] = 1'b1; full_line[456] = 1'b1;
        cursor_col = 4'd8; cursor_row = 4'd9; cursor_en = 1'b1;
        apply_reset();
        run_frame();
        total++;
        if (rgb_mem[432][488] !== 12'hDA6) begin
            bad++; $display("FAIL cursor_frame0: got %h want DA6", rgb_mem[432][488]);
        end
        for (int i = 0; i < 15; i++) frame_blank();
        run_frame();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rgb_mem[pv[i]][ph[i]] !== ex[i]) begin
                bad++;
                $display("FAIL cursor_px(%0d,%0d): got %h want %h", ph[i], pv[i], rgb_mem[pv[i]][ph[i]], ex[i]);
            end
        end
        cursor_col = 4'd9;
        run_frame();
        total++;
        if (rgb_mem[432][488] !== 12'hDA6) begin
            bad++; $display("FAIL cursor_col9: got %h want DA6", rgb_mem[432][488]);
        end
        cursor_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        int nonblack = 0;
        clear_setup();
        full_line[150] = 1'b1; full_line[300] = 1'b1;
        run_lines(0, 99);
        for (int h = 0; h <= 300; h++) step(1'b1, h, 100, 1'b1, 1'b1);
        total++; if (rgb !== 12'hDA6) begin bad++; $display("FAIL mid_pre_rgb: got %h want DA6", rgb); end
        total++; if (brd_addr !== 7'd22) begin bad++; $display("FAIL mid_pre_addr: got %0d want 22", brd_addr); end
        #2 reset = 1'b0;
        #1;
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL mid_rgb: got %h want 000", rgb); end
        total++; if (brd_addr !== 7'd0) begin bad++; $display("FAIL mid_addr: got %0d want 0", brd_addr); end
        total++; if (hsync !== 1'b1 || vsync !== 1'b1) begin bad++; $display("FAIL mid_sync: got %b%b want 11", hsync, vsync); end
        valid_in = 1'b0; h_cnt = 10'd0; v_cnt = 10'd0;
        repeat (2) @(negedge pclk);
        reset = 1'b1;
        flush();
        run_lines(101, 479);
        frame_blank();
        for (int h = 0; h < 640; h++) begin
            if (rgb_mem[150][h] !== 12'h000) nonblack++;
            if (rgb_mem[300][h] !== 12'h000) nonblack++;
        end
        total++; if (nonblack !== 0) begin bad++; $display("FAIL mid_black: got %0d non-black pixels want 0", nonblack); end
        run_frame();
        total++;
        if (rgb_mem[150][130] !== 12'hDA6) begin
            bad++; $display("FAIL mid_recover: got %h want DA6", rgb_mem[150][130]);
        end
    endtask

    task automatic test_sync;
        total++; if (sync_mism !== 0) begin bad++; $display("FAIL sync_delay: got %0d mismatching cycles want 0", sync_mism); end
        total++; if (sync_cnt < 10000) begin bad++; $display("FAIL sync_coverage: got %0d compared cycles want >=10000", sync_cnt); end
    endtask

    initial begin
        clear_setup();
        flush();
        test_reset();
        test_empty_board();
        test_pieces();
        test_brd_addr();
        test_cursor();
        test_reset_mid();
        test_sync();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
